// File: rtl/valid_ready_stim_gen_if.sv
// ---------------------------------------------------------------------------
// valid_ready_stim_gen_if
//   Valid/ready handshake bundle between the sender-side traffic generator and
//   the write port of the FIFO under test.
//
//   Signals:
//     out_valid  sender -> receiver  word on out_data is valid
//     out_ready  receiver -> sender  receiver accepts the word this cycle
//     out_data   sender -> receiver  payload, DATA_WIDTH bits
//
//   Modports:
//     master  the traffic generator (drives valid/data, samples ready)
//     slave   the consumer (samples valid/data, drives ready)
// ---------------------------------------------------------------------------
interface valid_ready_stim_gen_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/valid_ready_stim_gen.sv
// ---------------------------------------------------------------------------
// valid_ready_stim_gen
//   Sender-side valid/ready traffic generator. Each run emits NUM_SEQUENCE
//   words taken from a 16-bit Fibonacci LFSR (taps 16,14,13,11), with the
//   valid pattern shaped by the selected traffic mode. The run reports how
//   many handshakes completed and a 16-bit running sum of the words sent.
//
//   Ports:
//     clk_sender  in   clock, all logic on the rising edge
//     reset_n     in   synchronous active-low reset
//     start       in   one-cycle pulse, begins a run from IDLE or DONE
//     mode        in   0 PERFECT, 1 RANDOM, 2 BURST, 3 PERFECT (latched on start)
//     throttle    in   RANDOM valid threshold / BURST idle gap (latched on start)
//     bus         if   master side of the valid/ready/data handshake
//     busy        out  high while a run is in progress
//     done        out  high once the run has finished, until next start/reset
//     sent_count  out  handshakes completed in the current run
//     checksum    out  sum mod 2^16 of the words handed over this run
// ---------------------------------------------------------------------------
module valid_ready_stim_gen #(
    parameter int          DATA_WIDTH   = 8,
    parameter int          NUM_SEQUENCE = 16,
    parameter int          BURST_LEN    = 4,
    parameter logic [15:0] DATA_SEED    = 16'hACE1,
    parameter logic [15:0] GAP_SEED     = 16'h1D0F,
    parameter int          CNT_W        = $clog2(NUM_SEQUENCE + 1)
) (
    input  logic                     clk_sender,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [1:0]               mode,
    input  logic [3:0]               throttle,
    valid_ready_stim_gen_if.master   bus,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_W-1:0]         sent_count,
    output logic [15:0]              checksum
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam logic [1:0] MODE_PERFECT = 2'd0;
    localparam logic [1:0] MODE_RANDOM  = 2'd1;
    localparam logic [1:0] MODE_BURST   = 2'd2;

    localparam int               BURST_W    = $clog2(BURST_LEN + 1);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(NUM_SEQUENCE - 1);
    localparam logic [CNT_W:0]   TOTAL_WORDS = (CNT_W + 1)'(NUM_SEQUENCE);

    // One step of the shared 16-bit polynomial x^16+x^14+x^13+x^11+1,
    // shifting right with the feedback entering at bit 15.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    state_t               state_q;
    logic [1:0]           mode_q;
    logic [3:0]           throttle_q;
    logic [15:0]          data_lfsr_q;
    logic [15:0]          gap_lfsr_q;
    logic                 out_valid_q;
    logic [BURST_W-1:0]   burst_cnt_q;
    logic [3:0]           gap_cnt_q;

    logic                 handshake;
    logic                 last_handshake;
    logic [CNT_W:0]       count_after;
    logic                 remaining;
    logic                 want;
    logic                 valid_nxt;
    logic                 start_want;
    logic [BURST_W-1:0]   burst_cnt_nxt;
    logic [3:0]           gap_cnt_nxt;
    logic [DATA_WIDTH-1:0] data_word;

    assign data_word     = data_lfsr_q[DATA_WIDTH-1:0];
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = data_word;

    // Next-cycle valid decision. A word already on the bus stays there until
    // it is taken; a new word is offered only if the mode wants one and the
    // run still has words left after this cycle's handshake. In BURST mode
    // the burst/gap counters are advanced here so that "want" reflects the
    // cycle being scheduled, which makes the idle gap exactly throttle long.
    always_comb begin
        handshake      = (state_q == ST_RUN) && out_valid_q && bus.out_ready;
        last_handshake = handshake && (sent_count == LAST_COUNT);
        count_after    = {1'b0, sent_count} + {{CNT_W{1'b0}}, handshake};
        remaining      = (count_after < TOTAL_WORDS);
        burst_cnt_nxt  = burst_cnt_q;
        gap_cnt_nxt    = gap_cnt_q;
        want           = 1'b1;
        case (mode_q)
            MODE_PERFECT: want = 1'b1;
            MODE_RANDOM:  want = (gap_lfsr_q[3:0] >= throttle_q);
            MODE_BURST: begin
                if (handshake) begin
                    if (burst_cnt_q == BURST_LAST) begin
                        burst_cnt_nxt = '0;
                        gap_cnt_nxt   = throttle_q;
                    end else begin
                        burst_cnt_nxt = burst_cnt_q + BURST_W'(1);
                    end
                end else if (gap_cnt_q != 4'd0) begin
                    gap_cnt_nxt = gap_cnt_q - 4'd1;
                end
                want = (gap_cnt_nxt == 4'd0);
            end
            default: want = 1'b1;
        endcase
        valid_nxt  = (out_valid_q && !bus.out_ready) ||
                     (!last_handshake && want && remaining);
        // First valid of a run uses the incoming mode/throttle, because the
        // latched copies only take effect after the start edge.
        start_want = (mode == MODE_RANDOM) ? (gap_lfsr_q[3:0] >= throttle) : 1'b1;
    end

    // Run control FSM with all registered outputs. Start is honoured only in
    // IDLE or DONE; it reseeds the data LFSR so every run produces the same
    // word sequence. The gap LFSR free-runs through RUN cycles and is only
    // reseeded by reset, so RANDOM timing varies between runs while data
    // content does not.
    always_ff @(posedge clk_sender) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_PERFECT;
            throttle_q  <= 4'd0;
            data_lfsr_q <= DATA_SEED;
            gap_lfsr_q  <= GAP_SEED;
            out_valid_q <= 1'b0;
            burst_cnt_q <= '0;
            gap_cnt_q   <= 4'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            sent_count  <= '0;
            checksum    <= 16'd0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q     <= ST_RUN;
                        mode_q      <= mode;
                        throttle_q  <= throttle;
                        data_lfsr_q <= DATA_SEED;
                        out_valid_q <= start_want;
                        burst_cnt_q <= '0;
                        gap_cnt_q   <= 4'd0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        sent_count  <= '0;
                        checksum    <= 16'd0;
                    end
                end
                ST_RUN: begin
                    gap_lfsr_q  <= lfsr_step(gap_lfsr_q);
                    out_valid_q <= valid_nxt;
                    burst_cnt_q <= burst_cnt_nxt;
                    gap_cnt_q   <= gap_cnt_nxt;
                    if (handshake) begin
                        sent_count  <= sent_count + CNT_W'(1);
                        checksum    <= checksum + 16'(data_word);
                        data_lfsr_q <= lfsr_step(data_lfsr_q);
                    end
                    if (last_handshake) begin
                        state_q <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_valid_ready_stim_gen.sv
// ---------------------------------------------------------------------------
// tb_valid_ready_stim_gen
//   Self-checking bench for valid_ready_stim_gen. The expected word sequence
//   and checksum come from a plain arithmetic LFSR model; the handshake rules
//   (no valid withdrawal, burst shape, counts) are checked cycle by cycle.
// ---------------------------------------------------------------------------
module tb_valid_ready_stim_gen;

    localparam int NUM = 16;

    logic       clk_sender;
    logic       reset_n;
    logic       start;
    logic [1:0] mode;
    logic [3:0] throttle;
    logic       busy;
    logic       done;
    logic [4:0] sent_count;
    logic [15:0] checksum;

    valid_ready_stim_gen_if #(.DATA_WIDTH(8)) bus ();

    valid_ready_stim_gen dut (
        .clk_sender (clk_sender),
        .reset_n    (reset_n),
        .start      (start),
        .mode       (mode),
        .throttle   (throttle),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .sent_count (sent_count),
        .checksum   (checksum)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0]  exp_word [NUM];
    logic [15:0] exp_sum;

    bit valid_trace [$];
    int hs_count;
    int cyc_count;
    int hold_viol;
    int data_err;
    bit timed_out;

    initial clk_sender = 1'b0;
    always #5 clk_sender = ~clk_sender;

    // Absolute safety net in case a wait is ever left unbounded.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Spec polynomial x^16+x^14+x^13+x^11+1 written as a shift-right
    // Fibonacci step on an integer value.
    function automatic logic [15:0] model_next(input logic [15:0] s);
        logic [15:0] fb;
        fb = ((s >> 0) ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 16'h0001;
        return (s >> 1) | (fb << 15);
    endfunction

    task automatic build_model();
        logic [15:0] s;
        s = 16'hACE1;
        exp_sum = 16'd0;
        for (int i = 0; i < NUM; i++) begin
            exp_word[i] = s[7:0];
            exp_sum     = exp_sum + {8'd0, s[7:0]};
            s           = model_next(s);
        end
    endtask

    task automatic tick();
        @(posedge clk_sender);
        #1;
    endtask

    task automatic pulse_start(input logic [1:0] m, input logic [3:0] t);
        start    = 1'b1;
        mode     = m;
        throttle = t;
        tick();
        start    = 1'b0;
    endtask

    // Runs the consumer side until done, recording the valid trace, checking
    // each accepted word against the model and counting valid withdrawals.
    // ready_kind 0: always ready, 1: random ready with ready_pct percent.
    task automatic run_to_done(input int ready_kind, input int ready_pct,
                               input int start_idx, input int max_cycles);
        logic       prev_v;
        logic       prev_r;
        logic [7:0] prev_d;
        logic       rdy;
        hs_count  = start_idx;
        cyc_count = 0;
        hold_viol = 0;
        data_err  = 0;
        timed_out = 1'b0;
        valid_trace.delete();
        prev_v = 1'b0;
        prev_r = 1'b0;
        prev_d = 8'd0;
        while (done !== 1'b1) begin
            if (cyc_count >= max_cycles) begin
                timed_out = 1'b1;
                break;
            end
            if (prev_v && !prev_r && (bus.out_valid !== 1'b1 || bus.out_data !== prev_d))
                hold_viol++;
            valid_trace.push_back(bus.out_valid === 1'b1);
            rdy = (ready_kind == 0) ? 1'b1 : ($urandom_range(0, 99) < ready_pct);
            if (bus.out_valid === 1'b1 && rdy) begin
                if (hs_count >= NUM || bus.out_data !== exp_word[hs_count])
                    data_err++;
                hs_count++;
            end
            bus.out_ready = rdy;
            prev_v = bus.out_valid;
            prev_r = rdy;
            prev_d = bus.out_data;
            tick();
            cyc_count++;
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_valid got=%0b exp=0", bus.out_valid);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_busy_done got=%0b%0b exp=00", busy, done);
        end
        checks++;
        if (sent_count !== 5'd0 || checksum !== 16'd0) begin
            failures++; $display("[TB] FAIL reset_counters got=%0d/%h exp=0/0000", sent_count, checksum);
        end
        checks++;
        if (bus.out_data !== 8'hE1) begin
            failures++; $display("[TB] FAIL reset_data got=%h exp=e1", bus.out_data);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_perfect();
        pulse_start(2'd0, 4'd0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hE1) begin
            failures++; $display("[TB] FAIL perfect_first got=%0b/%h exp=1/e1", bus.out_valid, bus.out_data);
        end
        run_to_done(0, 100, 0, 100);
        checks++;
        if (timed_out || cyc_count != NUM) begin
            failures++; $display("[TB] FAIL perfect_cycles got=%0d exp=%0d", cyc_count, NUM);
        end
        checks++;
        if (valid_trace.size() != NUM || valid_trace.sum() with (int'(item)) != NUM) begin
            failures++; $display("[TB] FAIL perfect_trace got_ones=%0d exp=%0d",
                                 valid_trace.sum() with (int'(item)), NUM);
        end
        checks++;
        if (data_err != 0) begin
            failures++; $display("[TB] FAIL perfect_data got_errors=%0d exp=0", data_err);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || sent_count !== 5'd16) begin
            failures++; $display("[TB] FAIL perfect_done got=%0b/%0b/%0d exp=1/0/16", done, busy, sent_count);
        end
        checks++;
        if (checksum !== exp_sum) begin
            failures++; $display("[TB] FAIL perfect_checksum got=%h exp=%h", checksum, exp_sum);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || done !== 1'b1) begin
            failures++; $display("[TB] FAIL perfect_after got_valid=%0b done=%0b exp=0/1", bus.out_valid, done);
        end
    endtask

    task automatic test_stall();
        int stall_err;
        stall_err = 0;
        pulse_start(2'd0, 4'd0);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hE1 || sent_count !== 5'd0)
                stall_err++;
            tick();
        end
        checks++;
        if (stall_err != 0) begin
            failures++; $display("[TB] FAIL stall_hold got_bad_cycles=%0d exp=0", stall_err);
        end
        run_to_done(0, 100, 0, 100);
        checks++;
        if (timed_out || cyc_count != NUM || data_err != 0) begin
            failures++; $display("[TB] FAIL stall_transfer got=%0d cycles %0d errors exp=%0d/0",
                                 cyc_count, data_err, NUM);
        end
        checks++;
        if (sent_count !== 5'd16 || checksum !== exp_sum) begin
            failures++; $display("[TB] FAIL stall_totals got=%0d/%h exp=16/%h", sent_count, checksum, exp_sum);
        end
    endtask

    task automatic test_burst();
        int pat_err;
        pat_err = 0;
        pulse_start(2'd2, 4'd2);
        run_to_done(0, 100, 0, 200);
        for (int i = 0; i < valid_trace.size(); i++)
            if (valid_trace[i] != ((i % 6) < 4)) pat_err++;
        checks++;
        if (timed_out || cyc_count != 22) begin
            failures++; $display("[TB] FAIL burst_cycles got=%0d exp=22", cyc_count);
        end
        checks++;
        if (pat_err != 0) begin
            failures++; $display("[TB] FAIL burst_pattern got_bad_cycles=%0d exp=0", pat_err);
        end
        checks++;
        if (hs_count != NUM || data_err != 0 || sent_count !== 5'd16 || done !== 1'b1) begin
            failures++; $display("[TB] FAIL burst_totals got=%0d/%0d/%0d exp=16/0/16", hs_count, data_err, sent_count);
        end
    endtask

    task automatic test_random();
        pulse_start(2'd1, 4'd12);
        run_to_done(1, 60, 0, 3000);
        checks++;
        if (timed_out) begin
            failures++; $display("[TB] FAIL random_timeout got=%0d cycles exp=done", cyc_count);
        end
        checks++;
        if (hold_viol != 0) begin
            failures++; $display("[TB] FAIL random_withdraw got=%0d exp=0", hold_viol);
        end
        checks++;
        if (data_err != 0 || hs_count != NUM) begin
            failures++; $display("[TB] FAIL random_data got_err=%0d hs=%0d exp=0/16", data_err, hs_count);
        end
        checks++;
        if (checksum !== exp_sum || sent_count !== 5'd16) begin
            failures++; $display("[TB] FAIL random_checksum got=%h/%0d exp=%h/16", checksum, sent_count, exp_sum);
        end
    endtask

    task automatic test_midrun_reset();
        pulse_start(2'd0, 4'd0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (sent_count !== 5'd5) begin
            failures++; $display("[TB] FAIL midreset_count got=%0d exp=5", sent_count);
        end
        reset_n = 1'b0;
        tick();
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            sent_count !== 5'd0 || checksum !== 16'd0 || bus.out_data !== 8'hE1) begin
            failures++; $display("[TB] FAIL midreset_outputs got=%0b%0b%0b/%0d/%h/%h exp=000/0/0000/e1",
                                 bus.out_valid, busy, done, sent_count, checksum, bus.out_data);
        end
        reset_n = 1'b1;
        tick();
        pulse_start(2'd0, 4'd0);
        checks++;
        if (bus.out_data !== 8'hE1) begin
            failures++; $display("[TB] FAIL midreset_first got=%h exp=e1", bus.out_data);
        end
        run_to_done(0, 100, 0, 100);
        checks++;
        if (timed_out || data_err != 0 || checksum !== exp_sum) begin
            failures++; $display("[TB] FAIL midreset_rerun got_err=%0d sum=%h exp=0/%h", data_err, checksum, exp_sum);
        end
    endtask

    task automatic test_back_to_back();
        pulse_start(2'd0, 4'd0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        pulse_start(2'd2, 4'd5);
        checks++;
        if (sent_count !== 5'd4 || busy !== 1'b1) begin
            failures++; $display("[TB] FAIL run_start_ignored got=%0d/%0b exp=4/1", sent_count, busy);
        end
        run_to_done(0, 100, 4, 100);
        checks++;
        if (timed_out || cyc_count != NUM - 4 || data_err != 0 || checksum !== exp_sum) begin
            failures++; $display("[TB] FAIL run_continue got=%0d cycles %0d err sum %h exp=12/0/%h",
                                 cyc_count, data_err, checksum, exp_sum);
        end
        pulse_start(2'd0, 4'd0);
        checks++;
        if (sent_count !== 5'd0 || checksum !== 16'd0 || busy !== 1'b1 ||
            done !== 1'b0 || bus.out_data !== 8'hE1) begin
            failures++; $display("[TB] FAIL done_restart got=%0d/%h/%0b%0b/%h exp=0/0000/10/e1",
                                 sent_count, checksum, busy, done, bus.out_data);
        end
        run_to_done(1, 50, 0, 500);
        checks++;
        if (timed_out || data_err != 0 || checksum !== exp_sum || hold_viol != 0) begin
            failures++; $display("[TB] FAIL done_rerun got_err=%0d sum=%h hold=%0d exp=0/%h/0",
                                 data_err, checksum, hold_viol, exp_sum);
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        start         = 1'b0;
        mode          = 2'd0;
        throttle      = 4'd0;
        bus.out_ready = 1'b0;
        build_model();
        test_reset();
        test_perfect();
        test_stall();
        test_burst();
        test_random();
        test_midrun_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
